// File: rtl/e203_ifu_flush_recv.sv
// IFU flush receiver: accepts a commit-stage flush, drains in-flight fetch
// responses as stale, then presents a single redirect PC to the PC generator.
module e203_ifu_flush_recv #(
   parameter int PC_SIZE    = 32,
   parameter int OUTS_DEPTH = 2,
   parameter int CNT_W      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pipe_flush_req,
   input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
   input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
   output logic               pipe_flush_ack,
   input  logic               ifu_req_valid,
   input  logic               ifu_req_ready,
   input  logic               ifu_rsp_valid,
   input  logic               ifu_rsp_ready,
   output logic               rsp_discard,
   output logic               halt_fetch,
   output logic               redir_valid,
   input  logic               redir_ready,
   output logic [PC_SIZE-1:0] redir_pc,
   output logic               flush_busy
);

   // state | meaning
   // IDLE  | no flush pending, fetch runs freely
   // DRAIN | flush captured, discarding responses still in flight
   // REDIR | redirect PC presented, waiting for the PC generator
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] REDIR = 2'd2;

   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(OUTS_DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] outs_cnt, outs_nxt;
   logic [CNT_W-1:0] disc_cnt, disc_nxt;
   logic             req_hs, rsp_hs, flush_hs;

   assign req_hs   = ifu_req_valid & ifu_req_ready;
   assign rsp_hs   = ifu_rsp_valid & ifu_rsp_ready;
   assign flush_hs = pipe_flush_req & pipe_flush_ack;
   assign outs_nxt = outs_cnt + CNT_W'(req_hs) - CNT_W'(rsp_hs);

   // Ack depends only on state so there is no loop through the commit flush mux.
   assign pipe_flush_ack = (state != DRAIN);
   assign redir_valid    = (state == REDIR);
   assign flush_busy     = (state != IDLE);
   assign halt_fetch     = (state != IDLE) | (outs_cnt == DEPTH) | flush_hs;

   always_comb begin
      rsp_discard = 1'b0;
      case (state)
         IDLE:    rsp_discard = pipe_flush_req & ifu_rsp_valid;
         DRAIN:   rsp_discard = ifu_rsp_valid;
         default: rsp_discard = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      disc_nxt  = disc_cnt;
      case (state)
         IDLE: begin
            if (flush_hs) begin
               disc_nxt  = outs_nxt;
               state_nxt = (outs_nxt != '0) ? DRAIN : REDIR;
            end
         end
         DRAIN: begin
            if (rsp_hs) begin
               disc_nxt = disc_cnt - ONE;
               if (disc_cnt == ONE) state_nxt = REDIR;
            end
         end
         REDIR: begin
            // A new flush here replaces the pending redirect instead of consuming it.
            if (!flush_hs && redir_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         outs_cnt <= '0;
         disc_cnt <= '0;
         redir_pc <= '0;
      end else begin
         state    <= state_nxt;
         outs_cnt <= outs_nxt;
         disc_cnt <= disc_nxt;
         if (flush_hs) redir_pc <= pipe_flush_add_op1 + pipe_flush_add_op2;
      end
   end

   a_no_req_overflow: assert property (@(posedge clk) disable iff (rst)
      !(req_hs && (outs_cnt == DEPTH)));
   a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
      !(rsp_hs && (outs_cnt == '0)));

endmodule

// File: tb/tb_e203_ifu_flush_recv.sv
// Self-checking bench for e203_ifu_flush_recv: directed cycles plus a redirect
// scoreboard that expects each accepted flush target at the redirect handshake.
module tb_e203_ifu_flush_recv;

   logic        clk;
   logic        rst;
   logic        pipe_flush_req;
   logic [31:0] pipe_flush_add_op1;
   logic [31:0] pipe_flush_add_op2;
   logic        pipe_flush_ack;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_ready;
   logic        rsp_discard;
   logic        halt_fetch;
   logic        redir_valid;
   logic        redir_ready;
   logic [31:0] redir_pc;
   logic        flush_busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q[$];

   e203_ifu_flush_recv #(.PC_SIZE(32), .OUTS_DEPTH(2), .CNT_W(2)) dut (
      .clk                (clk),
      .rst                (rst),
      .pipe_flush_req     (pipe_flush_req),
      .pipe_flush_add_op1 (pipe_flush_add_op1),
      .pipe_flush_add_op2 (pipe_flush_add_op2),
      .pipe_flush_ack     (pipe_flush_ack),
      .ifu_req_valid      (ifu_req_valid),
      .ifu_req_ready      (ifu_req_ready),
      .ifu_rsp_valid      (ifu_rsp_valid),
      .ifu_rsp_ready      (ifu_rsp_ready),
      .rsp_discard        (rsp_discard),
      .halt_fetch         (halt_fetch),
      .redir_valid        (redir_valid),
      .redir_ready        (redir_ready),
      .redir_pc           (redir_pc),
      .flush_busy         (flush_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h", tag, act, exp);
      end
   endtask

   // Called #1 after inputs settle: scores a redirect handshake, then moves to the next negedge.
   task automatic adv();
      if (redir_valid && redir_ready) begin
         if (sb_q.size() == 0) chk("sb_unexpected_redir", redir_pc, 32'hxxxx_xxxx);
         else chk("sb_redir_pc", redir_pc, sb_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      pipe_flush_req     = 1'b0;
      pipe_flush_add_op1 = '0;
      pipe_flush_add_op2 = '0;
      ifu_req_valid      = 1'b0;
      ifu_req_ready      = 1'b0;
      ifu_rsp_valid      = 1'b0;
      ifu_rsp_ready      = 1'b0;
      redir_ready        = 1'b0;
   endtask

   task automatic flush(input logic [31:0] op1, input logic [31:0] op2);
      pipe_flush_req     = 1'b1;
      pipe_flush_add_op1 = op1;
      pipe_flush_add_op2 = op2;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ack", pipe_flush_ack, 1);
      chk("rst_redir_valid", redir_valid, 0);
      chk("rst_halt", halt_fetch, 0);
      chk("rst_discard", rsp_discard, 0);
      chk("rst_busy", flush_busy, 0);
      chk("rst_redir_pc", redir_pc, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Idle flush, nothing outstanding
      flush(32'h8000_0000, 32'h0000_0010);
      #1;
      chk("idle_ack", pipe_flush_ack, 1);
      chk("idle_halt_flush_cycle", halt_fetch, 1);
      chk("idle_discard_no_rsp", rsp_discard, 0);
      if (pipe_flush_ack) sb_q.push_back(32'h8000_0010);
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("idle_redir_valid_t1", redir_valid, 1);
      chk("idle_redir_pc_t1", redir_pc, 32'h8000_0010);
      chk("idle_busy_t1", flush_busy, 1);
      adv();
      idle_inputs();
      #1;
      chk("idle_busy_t2", flush_busy, 0);
      chk("idle_redir_valid_t2", redir_valid, 0);
      chk("idle_halt_t2", halt_fetch, 0);
      adv();

      // Drain two outstanding fetches
      for (int i = 0; i < 2; i++) begin
         ifu_req_valid = 1'b1;
         ifu_req_ready = 1'b1;
         #1;
         chk("drain_halt_before_fill", halt_fetch, 0);
         adv();
      end
      idle_inputs();
      #1;
      chk("drain_halt_full", halt_fetch, 1);
      adv();
      flush(32'h0000_0100, 32'h0000_0004);
      #1;
      chk("drain_ack", pipe_flush_ack, 1);
      if (pipe_flush_ack) sb_q.push_back(32'h0000_0104);
      adv();
      idle_inputs();
      flush(32'hDEAD_0000, 32'h0000_BEEF);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_ready = 1'b1;
      #1;
      chk("drain_ack_low", pipe_flush_ack, 0);
      chk("drain_busy", flush_busy, 1);
      chk("drain_halt", halt_fetch, 1);
      chk("drain_discard_rsp1", rsp_discard, 1);
      chk("drain_no_redir_rsp1", redir_valid, 0);
      adv();
      idle_inputs();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_ready = 1'b1;
      #1;
      chk("drain_discard_rsp2", rsp_discard, 1);
      chk("drain_no_redir_rsp2", redir_valid, 0);
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("drain_redir_valid", redir_valid, 1);
      chk("drain_redir_pc", redir_pc, 32'h0000_0104);
      chk("drain_discard_redir", rsp_discard, 0);
      adv();
      idle_inputs();
      #1;
      chk("drain_back_idle", flush_busy, 0);
      adv();

      // Same-cycle request and response during the flush
      ifu_req_valid = 1'b1;
      ifu_req_ready = 1'b1;
      #1;
      adv();
      idle_inputs();
      flush(32'h0000_1000, 32'h0000_0020);
      ifu_req_valid = 1'b1;
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_ready = 1'b1;
      #1;
      chk("same_ack", pipe_flush_ack, 1);
      chk("same_discard", rsp_discard, 1);
      chk("same_halt", halt_fetch, 1);
      if (pipe_flush_ack) sb_q.push_back(32'h0000_1020);
      adv();
      idle_inputs();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_ready = 1'b1;
      #1;
      chk("same_busy_drain", flush_busy, 1);
      chk("same_no_redir_yet", redir_valid, 0);
      chk("same_discard_drain", rsp_discard, 1);
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("same_redir_valid", redir_valid, 1);
      adv();
      idle_inputs();
      #1;
      adv();

      // Wrap of the target adder
      flush(32'hFFFF_FFFC, 32'h0000_0008);
      redir_ready = 1'b1;
      #1;
      if (pipe_flush_ack) sb_q.push_back(32'h0000_0004);
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("wrap_redir_pc", redir_pc, 32'h0000_0004);
      adv();
      idle_inputs();
      #1;
      adv();

      // Overwrite a pending redirect
      flush(32'h0000_0300, 32'h0000_0000);
      #1;
      if (pipe_flush_ack) sb_q.push_back(32'h0000_0300);
      adv();
      idle_inputs();
      #1;
      chk("ovw_hold_valid", redir_valid, 1);
      chk("ovw_hold_pc", redir_pc, 32'h0000_0300);
      adv();
      flush(32'h0000_0200, 32'h0000_0000);
      #1;
      chk("ovw_ack", pipe_flush_ack, 1);
      chk("ovw_pc_before", redir_pc, 32'h0000_0300);
      if (pipe_flush_ack) begin
         if (sb_q.size() != 0) void'(sb_q.pop_back());
         sb_q.push_back(32'h0000_0200);
      end
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("ovw_valid_after", redir_valid, 1);
      chk("ovw_pc_after", redir_pc, 32'h0000_0200);
      adv();
      idle_inputs();
      #1;
      chk("ovw_single_redir", redir_valid, 0);
      chk("ovw_sb_drained", sb_q.size(), 0);
      adv();

      // Reset while draining
      ifu_req_valid = 1'b1;
      ifu_req_ready = 1'b1;
      #1;
      adv();
      idle_inputs();
      flush(32'h0000_0400, 32'h0000_0008);
      #1;
      adv();
      idle_inputs();
      #1;
      chk("rstd_busy_before", flush_busy, 1);
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("rstd_busy", flush_busy, 0);
      chk("rstd_redir_valid", redir_valid, 0);
      chk("rstd_halt", halt_fetch, 0);
      chk("rstd_ack", pipe_flush_ack, 1);
      adv();
      rst = 1'b0;
      #1;
      adv();
      // With the outstanding count cleared, an idle flush redirects on the next cycle.
      flush(32'h0000_0500, 32'h0000_0001);
      #1;
      if (pipe_flush_ack) sb_q.push_back(32'h0000_0501);
      adv();
      idle_inputs();
      redir_ready = 1'b1;
      #1;
      chk("rstd_outs_cleared", redir_valid, 1);
      adv();
      idle_inputs();
      #1;
      chk("final_sb_empty", sb_q.size(), 0);
      adv();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/e203_ifu_flush_recv.md
# e203_ifu_flush_recv

IFU-side flush receiver sitting directly downstream of the EXU commit stage's pipe-flush interface. Accepts the commit stage's flush request together with its two adder operands, computes the redirect PC, and drains any instruction-fetch bus transactions already in flight so their stale responses get discarded. Only then does it hand a single redirect to the PC generator. While a flush is being processed it halts new fetch requests.

## Interface
Parameters:
- PC_SIZE, 32, width of PCs and flush adder operands
- OUTS_DEPTH, 2, maximum outstanding fetch requests on the IFU bus
- CNT_W, 2, counter width; must hold 0..OUTS_DEPTH

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_flush_req  in  1  flush request from commit stage
- pipe_flush_add_op1  in  PC_SIZE  flush target operand 1
- pipe_flush_add_op2  in  PC_SIZE  flush target operand 2
- pipe_flush_ack  out  1  flush accepted this cycle when high with req
- ifu_req_valid  in  1  fetch bus request valid
- ifu_req_ready  in  1  fetch bus request accepted
- ifu_rsp_valid  in  1  fetch bus response valid
- ifu_rsp_ready  in  1  fetch unit consumes response
- rsp_discard  out  1  current response is stale; fetch unit drops it, holding ifu_rsp_ready high
- halt_fetch  out  1  fetch unit must not raise ifu_req_valid
- redir_valid  out  1  redirect PC available
- redir_ready  in  1  PC generator accepts redirect
- redir_pc  out  PC_SIZE  redirect target
- flush_busy  out  1  state is not IDLE

## Operation
- Handshakes:
  - req_hs = ifu_req_valid & ifu_req_ready
  - rsp_hs = ifu_rsp_valid & ifu_rsp_ready
  - flush_hs = pipe_flush_req & pipe_flush_ack
- outs_cnt (CNT_W):
  - Next value is outs_cnt + req_hs - rsp_hs.
  - req_hs when outs_cnt == OUTS_DEPTH is illegal. halt_fetch prevents it.
  - rsp_hs when outs_cnt == 0 is illegal. Flag both cases with an assertion.
- Target PC: op1 + op2 modulo 2^PC_SIZE. The carry is dropped and the result wraps.
- FSM states: IDLE, DRAIN, REDIR.
- IDLE:
  - pipe_flush_ack = 1.
  - On flush_hs: capture redir_pc <= op1+op2 and disc_cnt <= outs_cnt + req_hs - rsp_hs (the post-cycle outstanding count).
  - Next state is DRAIN if that count is nonzero, else REDIR.
  - rsp_discard = pipe_flush_req & ifu_rsp_valid. A response arriving in the flush cycle is stale.
- DRAIN:
  - pipe_flush_ack = 0, so any new flush request waits.
  - rsp_discard = ifu_rsp_valid.
  - Each rsp_hs decrements disc_cnt.
  - When disc_cnt == 1 and rsp_hs, go to REDIR.
- REDIR:
  - redir_valid = 1 and pipe_flush_ack = 1.
  - On redir_ready with no flush_hs: go to IDLE.
  - On flush_hs, with or without redir_ready: redir_pc is overwritten with the new op1+op2 and the state stays REDIR. The latest flush wins and the old redirect is not consumed.
  - outs_cnt is 0 here because fetch is halted.
- halt_fetch = (state != IDLE) | (outs_cnt == OUTS_DEPTH) | flush_hs.
- flush_busy = (state != IDLE).
- Reset:
  - State and counters: state IDLE, outs_cnt 0, disc_cnt 0, redir_pc 0.
  - Outputs: redir_valid 0, halt_fetch 0, rsp_discard 0, flush_busy 0, pipe_flush_ack 1.

## Timing
- pipe_flush_ack is combinational from state only. It has no path from pipe_flush_req, which avoids a loop with the commit stage's flush mux.
- Redirect latency:
  - Flush accepted at cycle T with nothing outstanding: redir_valid rises at T+1.
  - With N outstanding: redir_valid rises the cycle after the Nth response handshake.
- redir_pc and redir_valid are registered. They are stable while redir_valid is high and redir_ready is low, except when a new flush_hs overwrites redir_pc.
- rsp_discard and halt_fetch are combinational from registered state plus flush_hs/valid inputs.
- Asserting rst mid-DRAIN or mid-REDIR drops the pending redirect immediately, with no redir_valid pulse. The commit stage re-issues after reset.
- Simultaneous req_hs and rsp_hs in the same cycle leave outs_cnt unchanged.

## Test plan
- Idle flush: outs_cnt=0, flush with op1=0x8000_0000, op2=0x0000_0010 at T -> ack=1 at T; redir_valid=1 and redir_pc=0x8000_0010 at T+1; redir_ready at T+1 -> IDLE at T+2.
- Drain two: two req_hs (outs_cnt=2), then flush op1=0x100, op2=0x4 -> DRAIN, halt_fetch=1. Two responses show rsp_discard=1. redir_valid rises the cycle after the second rsp_hs with redir_pc=0x104.
- Same-cycle edges: flush cycle with req_hs=1, rsp_hs=1 and outs_cnt=1 -> disc_cnt=1, rsp_discard=1 that cycle; one more response, then REDIR.
- Wrap: op1=0xFFFF_FFFC, op2=0x8 -> redir_pc=0x0000_0004.
- Overwrite: in REDIR with redir_ready=0, new flush op1=0x200, op2=0 -> ack=1; redir_pc becomes 0x200 next cycle; a single redir handshake follows.
- Reset mid-DRAIN: assert rst with disc_cnt=1 -> next sampled state IDLE, outs_cnt=0, redir_valid=0, halt_fetch=0, pipe_flush_ack=1.
